// File: rtl/store_buffer.sv
// Store buffer: packs stores into big-endian 512-bit lines, queues them for L2 and sequences
// synchronized stores. Define STBUF_FORWARD_EN to enable store-to-load byte forwarding.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ma_store_en,
  input  logic [3:0]   ma_store_op,
  input  logic [31:0]  ma_store_addr,
  input  logic [511:0] ma_store_value,
  input  logic [15:0]  ma_store_mask,
  input  logic [3:0]   ma_reg_lane_select,
  output logic         stbuf_rollback,
  output logic         sync_result_valid,
  output logic [511:0] sync_result,
  output logic         l2_req_valid,
  input  logic         l2_req_ack,
  output logic [25:0]  l2_req_addr,
  output logic [511:0] l2_req_data,
  output logic [63:0]  l2_req_mask,
  output logic         l2_req_sync,
  input  logic         l2_rsp_valid,
  input  logic         l2_rsp_status,
  input  logic [25:0]  fwd_addr,
  output logic         fwd_hit,
  output logic [511:0] fwd_data,
  output logic [63:0]  fwd_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MERGE_MIN  = CNT_W'(2);

  localparam logic [3:0] MEM_B          = 4'd0;
  localparam logic [3:0] MEM_BX         = 4'd1;
  localparam logic [3:0] MEM_S          = 4'd2;
  localparam logic [3:0] MEM_SX         = 4'd3;
  localparam logic [3:0] MEM_L          = 4'd4;
  localparam logic [3:0] MEM_SYNC       = 4'd5;
  localparam logic [3:0] MEM_BLOCK      = 4'd7;
  localparam logic [3:0] MEM_BLOCK_M    = 4'd8;
  localparam logic [3:0] MEM_BLOCK_IM   = 4'd9;
  localparam logic [3:0] MEM_STRIDED    = 4'd10;
  localparam logic [3:0] MEM_STRIDED_M  = 4'd11;
  localparam logic [3:0] MEM_STRIDED_IM = 4'd12;
  localparam logic [3:0] MEM_SCGATH     = 4'd13;
  localparam logic [3:0] MEM_SCGATH_M   = 4'd14;
  localparam logic [3:0] MEM_SCGATH_IM  = 4'd15;

  typedef enum logic [1:0] {StIdle, StWait, StDone} sync_state_e;

  sync_state_e state_q, state_d;
  logic [29:0] sync_addr_q, sync_addr_d;
  logic        status_q, status_d;

  logic [25:0]  ent_addr_q [DEPTH];
  logic [511:0] ent_data_q [DEPTH];
  logic [63:0]  ent_mask_q [DEPTH];
  logic         ent_sync_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  logic [511:0] st_data, st_bits, merged_data;
  logic [63:0]  st_mask;
  logic [31:0]  lane_val;
  logic         lane_en;
  logic         is_sync, can_merge, push, merge, pop, rollback, sync_done;

  // Format the incoming store as a line image; bytes outside st_mask stay zero.
  always_comb begin
    st_data  = '0;
    st_mask  = '0;
    lane_val = '0;
    lane_en  = 1'b0;
    for (int l = 0; l < 16; l++) begin
      if (4'(l) == ma_reg_lane_select) begin
        lane_val = ma_store_value[32*l +: 32];
        lane_en  = ma_store_mask[l];
      end
    end
    case (ma_store_op)
      MEM_B, MEM_BX: begin
        for (int b = 0; b < 64; b++) begin
          if (6'(b) == ma_store_addr[5:0]) begin
            st_data[511-8*b -: 8] = ma_store_value[7:0];
            st_mask[63-b]         = 1'b1;
          end
        end
      end
      MEM_S, MEM_SX: begin
        for (int h = 0; h < 32; h++) begin
          if (5'(h) == ma_store_addr[5:1]) begin
            st_data[511-16*h -: 16] = ma_store_value[15:0];
            st_mask[63-2*h -: 2]    = 2'b11;
          end
        end
      end
      MEM_L, MEM_SYNC: begin
        for (int w = 0; w < 16; w++) begin
          if (4'(w) == ma_store_addr[5:2]) begin
            st_data[511-32*w -: 32] = ma_store_value[31:0];
            st_mask[63-4*w -: 4]    = 4'hf;
          end
        end
      end
      MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM: begin
        // Register lane 15-w lands byte-swapped in memory word w.
        for (int w = 0; w < 16; w++) begin
          if (ma_store_mask[15-w]) begin
            st_data[511-32*w -: 32] = {ma_store_value[32*(15-w) +: 8],
                                       ma_store_value[32*(15-w) + 8 +: 8],
                                       ma_store_value[32*(15-w) + 16 +: 8],
                                       ma_store_value[32*(15-w) + 24 +: 8]};
            st_mask[63-4*w -: 4]    = 4'hf;
          end
        end
      end
      MEM_STRIDED, MEM_STRIDED_M, MEM_STRIDED_IM,
      MEM_SCGATH, MEM_SCGATH_M, MEM_SCGATH_IM: begin
        for (int w = 0; w < 16; w++) begin
          if (lane_en && (4'(w) == ma_store_addr[5:2])) begin
            st_data[511-32*w -: 32] = lane_val;
            st_mask[63-4*w -: 4]    = 4'hf;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    st_bits = '0;
    for (int j = 0; j < 64; j++) begin
      st_bits[8*j +: 8] = {8{st_mask[j]}};
    end
  end

  assign is_sync     = (ma_store_op == MEM_SYNC);
  assign tail_ptr    = wr_ptr_q - PTR_W'(1);
  assign can_merge   = (count_q >= MERGE_MIN) && (ent_addr_q[tail_ptr] == ma_store_addr[31:6]) &&
                       !ent_sync_q[tail_ptr];
  assign merged_data = (ent_data_q[tail_ptr] & ~st_bits) | st_data;
  assign pop         = l2_req_ack && (count_q != '0);
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d     = state_q;
    sync_addr_d = sync_addr_q;
    status_d    = status_q;
    push        = 1'b0;
    merge       = 1'b0;
    rollback    = 1'b0;
    sync_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ma_store_en) begin
          if (is_sync) begin
            rollback = 1'b1;
            if (count_q == '0) begin
              push        = 1'b1;
              sync_addr_d = ma_store_addr[31:2];
              state_d     = StWait;
            end
          end else if (st_mask != '0) begin
            // Full is judged on the pre-pop count; a merge needs no free slot.
            if (can_merge) begin
              merge = 1'b1;
            end else if (count_q < FULL_COUNT) begin
              push = 1'b1;
            end else begin
              rollback = 1'b1;
            end
          end
        end
      end
      StWait: begin
        rollback = ma_store_en;
        if (l2_rsp_valid) begin
          status_d = l2_rsp_status;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (ma_store_en) begin
          if (is_sync && (ma_store_addr[31:2] == sync_addr_q)) begin
            sync_done = 1'b1;
            state_d   = StIdle;
          end else begin
            rollback = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sync_addr_q <= '0;
      status_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_mask_q[i] <= '0;
        ent_sync_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      sync_addr_q <= sync_addr_d;
      status_q    <= status_d;
      count_q     <= count_d;
      if (push) begin
        ent_addr_q[wr_ptr_q] <= ma_store_addr[31:6];
        ent_data_q[wr_ptr_q] <= st_data;
        ent_mask_q[wr_ptr_q] <= st_mask;
        ent_sync_q[wr_ptr_q] <= is_sync;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (merge) begin
        ent_data_q[tail_ptr] <= merged_data;
        ent_mask_q[tail_ptr] <= ent_mask_q[tail_ptr] | st_mask;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign stbuf_rollback    = rollback;
  assign sync_result_valid = sync_done;
  assign sync_result       = {16{{31'b0, status_q}}};
  assign l2_req_valid      = (count_q != '0);
  assign l2_req_addr       = ent_addr_q[rd_ptr_q];
  assign l2_req_data       = ent_data_q[rd_ptr_q];
  assign l2_req_mask       = ent_mask_q[rd_ptr_q];
  assign l2_req_sync       = ent_sync_q[rd_ptr_q];

`ifdef STBUF_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so younger entries overwrite older bytes.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (ent_addr_q[fwd_idx] == fwd_addr)) begin
        for (int j = 0; j < 64; j++) begin
          if (ent_mask_q[fwd_idx][j]) begin
            fwd_data[8*j +: 8] = ent_data_q[fwd_idx][8*j +: 8];
            fwd_mask[j]        = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_hit = |fwd_mask;
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign fwd_mask = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic against a byte-level queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic         clk, reset;
  logic         ma_store_en;
  logic [3:0]   ma_store_op;
  logic [31:0]  ma_store_addr;
  logic [511:0] ma_store_value;
  logic [15:0]  ma_store_mask;
  logic [3:0]   ma_reg_lane_select;
  logic         stbuf_rollback, sync_result_valid;
  logic [511:0] sync_result;
  logic         l2_req_valid, l2_req_ack;
  logic [25:0]  l2_req_addr;
  logic [511:0] l2_req_data;
  logic [63:0]  l2_req_mask;
  logic         l2_req_sync, l2_rsp_valid, l2_rsp_status;
  logic [25:0]  fwd_addr;
  logic         fwd_hit;
  logic [511:0] fwd_data;
  logic [63:0]  fwd_mask;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ma_store_en(ma_store_en), .ma_store_op(ma_store_op), .ma_store_addr(ma_store_addr),
    .ma_store_value(ma_store_value), .ma_store_mask(ma_store_mask),
    .ma_reg_lane_select(ma_reg_lane_select),
    .stbuf_rollback(stbuf_rollback), .sync_result_valid(sync_result_valid),
    .sync_result(sync_result),
    .l2_req_valid(l2_req_valid), .l2_req_ack(l2_req_ack), .l2_req_addr(l2_req_addr),
    .l2_req_data(l2_req_data), .l2_req_mask(l2_req_mask), .l2_req_sync(l2_req_sync),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_status(l2_rsp_status),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_mask(fwd_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0]  line;
    logic [511:0] data;
    logic [63:0]  mask;
    logic         sync;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t mq[$];
  int mstate;  // 0 idle, 1 waiting for L2 response, 2 response received
  logic [29:0] m_sync_addr;
  logic        m_status;
  logic         s_rollback, s_sync_valid, s_fwd_hit;
  logic [511:0] s_sync_result, s_fwd_data;
  logic [25:0]  lines [4];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] expand(input logic [63:0] m);
    logic [511:0] e;
    for (int j = 0; j < 64; j++) e[8*j +: 8] = {8{m[j]}};
    return e;
  endfunction

  // Line image of one store, built byte by byte: {data, byte-enable mask}.
  function automatic logic [575:0] build(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [511:0] value, input logic [15:0] lmask,
                                         input logic [3:0] lsel);
    logic [7:0]   by [64];
    logic         en [64];
    logic [511:0] d;
    logic [63:0]  m;
    logic [31:0]  lane;
    int b, w, l;
    for (int i = 0; i < 64; i++) begin by[i] = 8'h0; en[i] = 1'b0; end
    b = int'(addr[5:0]);
    w = int'(addr[5:2]);
    l = int'(lsel);
    case (op)
      4'd0, 4'd1: begin by[b] = value[7:0]; en[b] = 1'b1; end
      4'd2, 4'd3: begin
        b = b - (b % 2);
        by[b] = value[15:8]; by[b+1] = value[7:0]; en[b] = 1'b1; en[b+1] = 1'b1;
      end
      4'd4, 4'd5: for (int k = 0; k < 4; k++) begin
        by[4*w+k] = value[31-8*k -: 8]; en[4*w+k] = 1'b1;
      end
      4'd7, 4'd8, 4'd9: for (int ww = 0; ww < 16; ww++) begin
        if (lmask[15-ww]) begin
          lane = value[32*(15-ww) +: 32];
          for (int k = 0; k < 4; k++) begin by[4*ww+k] = lane[8*k +: 8]; en[4*ww+k] = 1'b1; end
        end
      end
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: if (lmask[l]) begin
        lane = value[32*l +: 32];
        for (int k = 0; k < 4; k++) begin by[4*w+k] = lane[31-8*k -: 8]; en[4*w+k] = 1'b1; end
      end
      default: ;
    endcase
    for (int i = 0; i < 64; i++) begin d[511-8*i -: 8] = by[i]; m[63-i] = en[i]; end
    return {d, m};
  endfunction

  task automatic store(input logic [3:0] op, input logic [31:0] addr, input logic [511:0] value,
                       input logic [15:0] lmask, input logic [3:0] lsel);
    ma_store_en = 1'b1; ma_store_op = op; ma_store_addr = addr; ma_store_value = value;
    ma_store_mask = lmask; ma_reg_lane_select = lsel;
  endtask

  // One clock: compare at the falling edge, then advance the model over the rising edge.
  task automatic tick();
    logic [575:0] bm;
    logic [511:0] sdata, fd;
    logic [63:0]  smask, fm;
    logic exp_rb, exp_sv, do_push, do_merge, is_sync;
    int nstate;
    ent_t e;
    @(negedge clk);
    bm = build(ma_store_op, ma_store_addr, ma_store_value, ma_store_mask, ma_reg_lane_select);
    sdata = bm[575:64];
    smask = bm[63:0];
    is_sync = (ma_store_op == 4'd5);
    exp_rb = 1'b0; exp_sv = 1'b0; do_push = 1'b0; do_merge = 1'b0; nstate = mstate;
    if (ma_store_en) begin
      if (mstate == 0) begin
        if (is_sync) begin
          exp_rb = 1'b1;
          if (mq.size() == 0) begin do_push = 1'b1; nstate = 1; end
        end else if (smask != 64'h0) begin
          if (mq.size() >= 2 && mq[$].line == ma_store_addr[31:6] && !mq[$].sync) do_merge = 1'b1;
          else if (mq.size() < DEPTH) do_push = 1'b1;
          else exp_rb = 1'b1;
        end
      end else if (mstate == 1) begin
        exp_rb = 1'b1;
      end else begin
        if (is_sync && ma_store_addr[31:2] == m_sync_addr) begin exp_sv = 1'b1; nstate = 0; end
        else exp_rb = 1'b1;
      end
    end
    fd = '0; fm = '0;
`ifdef STBUF_FORWARD_EN
    foreach (mq[i]) begin
      if (mq[i].line == fwd_addr) begin
        for (int j = 0; j < 64; j++) begin
          if (mq[i].mask[j]) begin fd[8*j +: 8] = mq[i].data[8*j +: 8]; fm[j] = 1'b1; end
        end
      end
    end
`endif
    s_rollback = stbuf_rollback; s_sync_valid = sync_result_valid; s_sync_result = sync_result;
    s_fwd_hit = fwd_hit; s_fwd_data = fwd_data;
    chk("rollback", stbuf_rollback, exp_rb);
    chk("sync_result_valid", sync_result_valid, exp_sv);
    if (exp_sv) chk("sync_result", sync_result, {16{{31'b0, m_status}}});
    chk("l2_req_valid", l2_req_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("l2_req_addr", l2_req_addr, mq[0].line);
      chk("l2_req_mask", l2_req_mask, mq[0].mask);
      chk("l2_req_data", l2_req_data & expand(mq[0].mask), mq[0].data);
      chk("l2_req_sync", l2_req_sync, mq[0].sync);
    end
    chk("fwd_hit", fwd_hit, |fm);
    chk("fwd_mask", fwd_mask, fm);
`ifdef STBUF_FORWARD_EN
    chk("fwd_data", fwd_data & expand(fm), fd);
`else
    chk("fwd_data", fwd_data, fd);
`endif
    if (mstate == 1 && l2_rsp_valid) begin m_status = l2_rsp_status; nstate = 2; end
    if (do_push && is_sync) m_sync_addr = ma_store_addr[31:2];
    if (do_merge) begin
      e = mq[$];
      e.data = (e.data & ~expand(smask)) | sdata;
      e.mask = e.mask | smask;
      mq[$] = e;
    end
    if (l2_req_ack && mq.size() != 0) void'(mq.pop_front());
    if (do_push) begin
      e.line = ma_store_addr[31:6]; e.data = sdata; e.mask = smask; e.sync = is_sync;
      mq.push_back(e);
    end
    mstate = nstate;
    @(posedge clk);
    #1;
    ma_store_en = 1'b0; l2_req_ack = 1'b0; l2_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    mq.delete(); mstate = 0; m_status = 1'b0;
    chk("reset_l2_req_valid", l2_req_valid, 1'b0);
    chk("reset_l2_req_mask", l2_req_mask, 64'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [511:0] v;
    lines[0] = 26'h40; lines[1] = 26'h41; lines[2] = 26'h80; lines[3] = 26'h3ffffff;
    ma_store_en = 1'b0; ma_store_op = 4'h0; ma_store_addr = '0; ma_store_value = '0;
    ma_store_mask = '0; ma_reg_lane_select = '0; l2_req_ack = 1'b0; l2_rsp_valid = 1'b0;
    l2_rsp_status = 1'b0; fwd_addr = '0;
    mstate = 0; m_sync_addr = '0; m_status = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_l2_req_valid", l2_req_valid, 1'b0);
    chk("rst_l2_req_addr", l2_req_addr, 26'h0);
    chk("rst_l2_req_data", l2_req_data, 512'h0);
    chk("rst_l2_req_mask", l2_req_mask, 64'h0);
    chk("rst_l2_req_sync", l2_req_sync, 1'b0);
    chk("rst_rollback", stbuf_rollback, 1'b0);
    chk("rst_sync_valid", sync_result_valid, 1'b0);
    chk("rst_sync_result", sync_result, 512'h0);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Byte store
    store(4'd0, 32'h1003, 512'hab, 16'h0, 4'd0); tick();
    chk("byte_addr", l2_req_addr, 26'h40);
    chk("byte_mask", l2_req_mask, 64'h1000_0000_0000_0000);
    chk("byte_data", l2_req_data[487:480], 8'hab);
    l2_req_ack = 1'b1; tick();

    // Word store, then fill and overflow
    store(4'd4, 32'h2008, 512'h11223344, 16'h0, 4'd0); tick();
    chk("word_data", l2_req_data[447:416], 32'h11223344);
    chk("word_mask", l2_req_mask, 64'h00f0_0000_0000_0000);
    store(4'd4, 32'h2048, 512'h55667788, 16'h0, 4'd0); tick();
    store(4'd4, 32'h2088, 512'h99aabbcc, 16'h0, 4'd0); tick();
    store(4'd4, 32'h20c8, 512'hddeeff00, 16'h0, 4'd0); tick();
    store(4'd4, 32'h2108, 512'h12345678, 16'h0, 4'd0); tick();
    chk("full_rollback", s_rollback, 1'b1);
    chk("full_head_addr", l2_req_addr, 26'h80);
    for (int i = 0; i < DEPTH; i++) begin l2_req_ack = 1'b1; tick(); end
    chk("drained", l2_req_valid, 1'b0);

    // Merge into the tail entry
    store(4'd4, 32'h5000, 512'haaaaaaaa, 16'h0, 4'd0); tick();
    store(4'd4, 32'h5040, 512'h11223344, 16'h0, 4'd0); tick();
    store(4'd0, 32'h5041, 512'h99, 16'h0, 4'd0); tick();
    chk("merge_accept", s_rollback, 1'b0);
    l2_req_ack = 1'b1; tick();
    chk("merge_data", l2_req_data[511:480], 32'h11993344);
    chk("merge_mask", l2_req_mask, 64'hf000_0000_0000_0000);
    l2_req_ack = 1'b1; tick();
    chk("merge_one_entry", l2_req_valid, 1'b0);

    // Synchronized store
    store(4'd5, 32'h3000, 512'h5, 16'h0, 4'd0); tick();
    chk("sync_rollback", s_rollback, 1'b1);
    chk("sync_entry", l2_req_sync, 1'b1);
    l2_req_ack = 1'b1; tick();
    l2_rsp_valid = 1'b1; l2_rsp_status = 1'b1; tick();
    store(4'd5, 32'h3000, 512'h5, 16'h0, 4'd0); tick();
    chk("sync_done_valid", s_sync_valid, 1'b1);
    chk("sync_done_result", s_sync_result, {16{32'h1}});
    chk("sync_done_no_rb", s_rollback, 1'b0);

    // Block store
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    v[511:480] = 32'h01020304;
    v[31:0]    = 32'h0a0b0c0d;
    store(4'd7, 32'h4000, v, 16'h8001, 4'd0); tick();
    chk("block_word0", l2_req_data[511:480], 32'h04030201);
    chk("block_word15", l2_req_data[31:0], 32'h0d0c0b0a);
    chk("block_mask", l2_req_mask, 64'hf000_0000_0000_000f);
    l2_req_ack = 1'b1; tick();

    // Forwarding: younger byte wins
    store(4'd0, 32'h1003, 512'h11, 16'h0, 4'd0); tick();
    store(4'd0, 32'h1003, 512'h22, 16'h0, 4'd0); tick();
    fwd_addr = 26'h40; tick();
`ifdef STBUF_FORWARD_EN
    chk("fwd_dir_hit", s_fwd_hit, 1'b1);
    chk("fwd_dir_byte", s_fwd_data[487:480], 8'h22);
`else
    chk("fwd_dir_off", s_fwd_hit, 1'b0);
`endif
    l2_req_ack = 1'b1; tick();
    l2_req_ack = 1'b1; tick();

    // Reset during WAIT discards the pending response
    store(4'd5, 32'h3100, 512'h0, 16'h0, 4'd0); tick();
    l2_req_ack = 1'b1; tick();
    do_reset();
    l2_rsp_valid = 1'b1; l2_rsp_status = 1'b1; tick();
    store(4'd5, 32'h3100, 512'h0, 16'h0, 4'd0); tick();
    chk("reset_sync_rb", s_rollback, 1'b1);
    chk("reset_sync_nodone", s_sync_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] op;
      if (i == 1000) do_reset();
      op = 4'($urandom_range(0, 15));
      if (op == 4'd6) op = 4'd4;
      if (mstate == 2 && $urandom_range(0, 1) == 0) op = 4'd5;
      for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
      store(op, {lines[$urandom_range(0, 3)], 6'($urandom)}, v,
            ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom), 4'($urandom));
      if (op == 4'd5 && mstate == 2 && $urandom_range(0, 3) != 0)
        ma_store_addr = {m_sync_addr, 2'($urandom)};
      ma_store_en = ($urandom_range(0, 99) < 40);
      l2_req_ack = ($urandom_range(0, 1) == 0);
      if (mstate == 1 && mq.size() == 0 && $urandom_range(0, 3) == 0) begin
        l2_rsp_valid = 1'b1;
        l2_rsp_status = 1'($urandom);
      end
      fwd_addr = lines[$urandom_range(0, 3)];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load writeback path. It takes stores from the memory-access stage and converts register data into big-endian, line-aligned 512-bit data with a 64-bit byte-enable. It queues the stores in a small FIFO and drains them to L2 over a valid/ack request port. It also sequences synchronized stores and generates `stbuf_rollback` for the writeback stage.

## Interface
- `DEPTH`, default 4: number of FIFO entries; power of two, 2..8.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ma_store_en`  in  1  a store is in the memory-access stage this cycle.
- `ma_store_op`  in  4  store width/type; `instruction_format.h` encodings.
- `ma_store_addr`  in  32  effective byte address.
- `ma_store_value`  in  512  register value; lane k is bits [32k+31:32k].
- `ma_store_mask`  in  16  lane mask; bit k belongs to lane k.
- `ma_reg_lane_select`  in  4  source lane for strided and scatter stores.
- `stbuf_rollback`  out  1  combinational; the store was not accepted; roll back and suspend.
- `sync_result_valid`  out  1  combinational; a retried synchronized store is completing.
- `sync_result`  out  512  `{16{31'b0, status}}`.
- `l2_req_valid`  out  1  head entry is presented.
- `l2_req_ack`  in  1  L2 has taken the head entry.
- `l2_req_addr`  out  26  line address (addr[31:6]).
- `l2_req_data`  out  512  line data.
- `l2_req_mask`  out  64  byte enables.
- `l2_req_sync`  out  1  entry is a synchronized store.
- `l2_rsp_valid`  in  1  response to a synchronized store.
- `l2_rsp_status`  in  1  1 = synchronized store succeeded.
- `fwd_addr`  in  26  line address of a load lookup.
- `fwd_hit`  out  1  some pending byte matches.
- `fwd_data`  out  512  forwarded bytes.
- `fwd_mask`  out  64  bytes supplied by forwarding.

## Operation
- **Line layout:** line byte b sits at bits [511-8b:504-8b]; `l2_req_mask` bit 63-b enables byte b.
- **Byte store (MEM_B/MEM_BX):** value[7:0] is placed at byte addr[5:0]; one mask bit is set.
- **Halfword store (MEM_S/MEM_SX):**
  - value[15:8] goes to byte addr[5:0]&~1.
  - value[7:0] goes to the following byte.
- **Word store (MEM_L/MEM_SYNC):** value[31:0] goes big-endian to bytes 4w..4w+3, w = addr[5:2].
- **Block stores (MEM_BLOCK, _M, _IM):**
  - Register lane 15-w, byte-swapped, goes to memory word w.
  - Each memory word is enabled (4 bytes) when the corresponding register lane's `ma_store_mask` bit is set.
- **Strided and scatter stores:**
  - Lane `ma_reg_lane_select` is stored as a word at addr[5:2].
  - Nothing is stored if that lane's mask bit is clear.
- **Enqueue:**
  - A non-sync store is accepted when count<DEPTH, or when it merges.
  - Merge condition: count≥2 and the tail entry has the same line address and is not a sync entry.
  - On merge, new bytes overwrite per byte-enable and the masks are ORed.
- **Full:** if a store is not accepted, `stbuf_rollback`=1 in the same cycle and no state changes.
- **Drain:**
  - The head entry is always presented while count>0.
  - `l2_req_ack` pops it at the clock edge.
  - Push and pop in the same cycle are both legal; full is evaluated before the pop.
- **Sync state machine:**
  - **IDLE:**
    - A sync store with FIFO empty: enqueue it, latch addr[31:2], assert rollback, go to WAIT.
    - A sync store with FIFO non-empty: assert rollback, enqueue nothing.
  - **WAIT:**
    - Every store attempt gets rollback.
    - `l2_rsp_valid`: latch status, go to DONE.
  - **DONE:**
    - A sync store to the latched address: `sync_result_valid`=1, no rollback, no enqueue, go to IDLE.
    - Any other store: rollback.
- **Mid-operation reset:** FIFO contents are discarded, state goes to IDLE, and an in-flight L2 response is ignored.

## Timing
- **Reset values:** all outputs 0; count=0; pointers=0; state IDLE.
- **Request latency:** an accepted store is visible on `l2_req_*` the cycle after acceptance at the earliest.
- **Request outputs:** `l2_req_*` are registered and stable while valid and not acked.
- **Ack after pop:** the next entry appears in the cycle following the ack.
- **Response:** `l2_rsp_valid` is a single-cycle pulse and is meaningful only in WAIT.
- **Combinational outputs:** `stbuf_rollback` and `sync_result_valid` depend on the current-cycle inputs.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Configuration
- **`STBUF_FORWARD_EN` defined:**
  - `fwd_*` combinationally compares `fwd_addr` against all valid entries.
  - Per byte, the youngest matching entry supplies the data.
  - `fwd_hit` = |`fwd_mask`.
- **Undefined:** `fwd_hit`, `fwd_data` and `fwd_mask` are tied to 0 and the comparators are removed.

## Test plan
- Byte store, addr 0x1003, value 0xAB → next cycle: `l2_req_addr`=0x40, byte 3 = 0xAB, mask = 64'h1000_0000_0000_0000.
- Word store 0x11223344 to 0x2008 with `l2_req_ack` low → bytes 8..11 = 11 22 33 44; fill DEPTH entries; the next store gets `stbuf_rollback`=1 and the FIFO is unchanged.
- Two stores to the same line with count≥2 → they merge into one entry; later-store bytes win; masks ORed.
- Sync store 0x3000 → rollback=1; then `l2_rsp_valid` with status=1; retry → `sync_result_valid`=1, `sync_result` = {16{32'h1}}.
- Block store with mask 16'h8001 → words 0 and 15 enabled; mask = 64'hF000_0000_0000_000F; words byte-swapped.
- With `STBUF_FORWARD_EN`: two pending stores to line 0x40 writing byte 3 = 0x11 (older) then 0x22 → `fwd_addr`=0x40 gives hit=1, byte 3 = 0x22.
